crop_frame_ctrl: RTL and testbench

- Frame sequencer for crop_filter: gates the input pixel stream to one frame at a time.
- Generates the raster counters cnt_col/cnt_row, applies shadowed crop coordinates at frame boundaries, and issues ap_start.
- Waits for crop ap_done, then reports frame completion.
- Sits between the camera-side AXI stream and crop_filter; pixel data bypasses it, only handshakes and counters pass through.

---
 rtl/crop_frame_ctrl_pkg.sv | 20 ++
 rtl/crop_frame_ctrl_raster_counter.sv | 54 +++++
 rtl/crop_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_crop_frame_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_frame_ctrl_pkg.sv
// Shared types and width helpers for the crop frame sequencer.
package crop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STREAM,
    DRAIN,
    DONE
  } crop_state_t;

  function automatic int unsigned col_width(input int unsigned in_cols);
    return (in_cols > 1) ? $clog2(in_cols) : 1;
  endfunction

  function automatic int unsigned row_width(input int unsigned in_rows);
    return (in_rows > 1) ? $clog2(in_rows) : 1;
  endfunction

endpackage

// File: rtl/crop_frame_ctrl_raster_counter.sv
// Column/row raster counter: advances on i_en, clears on i_clr, flags the
// last pixel of the frame.
module raster_counter
  import crop_pkg::*;
#(
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_en,
  input  logic                            i_clr,
  output logic [col_width(IN_COLS)-1:0]   o_col,
  output logic [row_width(IN_ROWS)-1:0]   o_row,
  output logic                            o_last
);

  localparam int CW = col_width(IN_COLS);
  localparam int RW = row_width(IN_ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IN_ROWS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == COL_MAX);
  assign w_row_end = (r_row == ROW_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end & w_row_end;

endmodule

// File: rtl/crop_frame_ctrl.sv
// Frame sequencer for crop_filter: one frame at a time, shadowed crop origin,
// ap_start/ap_done handshake. Define CROP_WDOG_EN to add the DRAIN watchdog.
module crop_frame_ctrl
  import crop_pkg::*;
#(
  parameter int IN_ROWS  = 20,
  parameter int IN_COLS  = 20,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
`ifdef CROP_WDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          cfg_valid,
  input  logic [col_width(IN_COLS)-1:0] cfg_x0,
  input  logic [row_width(IN_ROWS)-1:0] cfg_y0,
  input  logic                          up_tvalid,
  output logic                          up_tready,
  output logic                          cf_tvalid,
  input  logic                          cf_tready,
  output logic [col_width(IN_COLS)-1:0] cnt_col,
  output logic [row_width(IN_ROWS)-1:0] cnt_row,
  output logic [col_width(IN_COLS)-1:0] crop_x0,
  output logic [row_width(IN_ROWS)-1:0] crop_y0,
  output logic                          cf_ap_start,
  input  logic                          cf_ap_done,
  input  logic                          cf_ap_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          cfg_clamped
`ifdef CROP_WDOG_EN
  , output logic                        wdog_err
`endif
);

  localparam int CW = col_width(IN_COLS);
  localparam int RW = row_width(IN_ROWS);
  localparam logic [CW-1:0] MAX_X0 = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] MAX_Y0 = RW'(IN_ROWS - OUT_ROWS);

  crop_state_t   r_state;
  logic [CW-1:0] r_shadow_x0;
  logic [RW-1:0] r_shadow_y0;
  logic [CW-1:0] r_crop_x0;
  logic [RW-1:0] r_crop_y0;
  logic          r_done_seen;
  logic          r_ap_start;
  logic          r_frame_done;
  logic [15:0]   r_frame_count;
  logic          r_cfg_clamped;

  logic          w_stream;
  logic          w_beat;
  logic          w_last;
  logic          w_start_ok;
  logic          w_done_now;
  logic          w_drain_exit;
  logic          w_x0_clamp;
  logic          w_y0_clamp;
  logic [CW-1:0] w_x0_sat;
  logic [RW-1:0] w_y0_sat;
  logic [CW-1:0] w_shadow_x0_nxt;
  logic [RW-1:0] w_shadow_y0_nxt;

  assign w_stream   = (r_state == STREAM);
  assign w_beat     = up_tvalid & cf_tready & w_stream;
  assign w_start_ok = enable & cf_ap_ready;
  assign w_done_now = r_done_seen | cf_ap_done;

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    w_x0_clamp      = int'(cfg_x0) > (IN_COLS - OUT_COLS);
    w_y0_clamp      = int'(cfg_y0) > (IN_ROWS - OUT_ROWS);
    w_x0_sat        = w_x0_clamp ? MAX_X0 : cfg_x0;
    w_y0_sat        = w_y0_clamp ? MAX_Y0 : cfg_y0;
    // Value the shadow holds once this cycle's cfg_valid has landed.
    w_shadow_x0_nxt = cfg_valid ? w_x0_sat : r_shadow_x0;
    w_shadow_y0_nxt = cfg_valid ? w_y0_sat : r_shadow_y0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_x0   <= '0;
      r_shadow_y0   <= '0;
      r_cfg_clamped <= 1'b0;
    end else if (cfg_valid) begin
      r_shadow_x0 <= w_x0_sat;
      r_shadow_y0 <= w_y0_sat;
      if (w_x0_clamp || w_y0_clamp) r_cfg_clamped <= 1'b1;
    end
  end

`ifdef CROP_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] r_wdog_cnt;
  logic          r_wdog_err;
  logic          w_wdog_hit;

  assign w_wdog_hit   = (r_wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign w_drain_exit = w_done_now | w_wdog_hit;
  assign wdog_err     = r_wdog_err;
`else
  assign w_drain_exit = w_done_now;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_crop_x0     <= '0;
      r_crop_y0     <= '0;
      r_done_seen   <= 1'b0;
      r_ap_start    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
`ifdef CROP_WDOG_EN
      r_wdog_cnt    <= '0;
      r_wdog_err    <= 1'b0;
`endif
    end else begin
      r_ap_start   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            // Latch the origin on entry so it is visible during ARM itself.
            r_state    <= ARM;
            r_ap_start <= 1'b1;
            r_crop_x0  <= w_shadow_x0_nxt;
            r_crop_y0  <= w_shadow_y0_nxt;
          end else begin
            r_state <= IDLE;
          end
        end
        ARM: begin
          r_done_seen <= 1'b0;
`ifdef CROP_WDOG_EN
          r_wdog_cnt  <= '0;
`endif
          r_state     <= STREAM;
        end
        STREAM: begin
          if (cf_ap_done) r_done_seen <= 1'b1;
          if (w_beat && w_last) r_state <= DRAIN;
        end
        DRAIN: begin
`ifdef CROP_WDOG_EN
          r_wdog_cnt <= r_wdog_cnt + 1'b1;
          if (!w_done_now && w_wdog_hit) r_wdog_err <= 1'b1;
`endif
          if (w_drain_exit) begin
            r_state       <= DONE;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  raster_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_beat),
    .i_clr  (r_state == ARM),
    .o_col  (cnt_col),
    .o_row  (cnt_row),
    .o_last (w_last)
  );

  assign up_tready   = cf_tready & w_stream;
  assign cf_tvalid   = up_tvalid & w_stream;
  assign busy        = (r_state != IDLE);
  assign crop_x0     = r_crop_x0;
  assign crop_y0     = r_crop_y0;
  assign cf_ap_start = r_ap_start;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign cfg_clamped = r_cfg_clamped;

endmodule

// File: tb/tb_crop_frame_ctrl.sv
// Self-checking bench for crop_frame_ctrl (8x8 in, 4x4 crop); the watchdog
// scenario runs when CROP_WDOG_EN is defined.
module tb_crop_frame_ctrl;

  localparam int R    = 8;
  localparam int C    = 8;
  localparam int OR   = 4;
  localparam int OC   = 4;
  localparam int NPIX = R * C;
`ifdef CROP_WDOG_EN
  localparam int WD   = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_valid;
  logic [2:0]  cfg_x0;
  logic [2:0]  cfg_y0;
  logic        up_tvalid = 1'b0;
  logic        up_tready;
  logic        cf_tvalid;
  logic        cf_tready = 1'b0;
  logic [2:0]  cnt_col;
  logic [2:0]  cnt_row;
  logic [2:0]  crop_x0;
  logic [2:0]  crop_y0;
  logic        cf_ap_start;
  logic        cf_ap_done = 1'b0;
  logic        cf_ap_ready;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        cfg_clamped;
`ifdef CROP_WDOG_EN
  logic        wdog_err;
`endif

  crop_frame_ctrl #(
    .IN_ROWS  (R),
    .IN_COLS  (C),
    .OUT_ROWS (OR),
    .OUT_COLS (OC)
`ifdef CROP_WDOG_EN
    , .WDOG_CYCLES (WD)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_x0      (cfg_x0),
    .cfg_y0      (cfg_y0),
    .up_tvalid   (up_tvalid),
    .up_tready   (up_tready),
    .cf_tvalid   (cf_tvalid),
    .cf_tready   (cf_tready),
    .cnt_col     (cnt_col),
    .cnt_row     (cnt_row),
    .crop_x0     (crop_x0),
    .crop_y0     (crop_y0),
    .cf_ap_start (cf_ap_start),
    .cf_ap_done  (cf_ap_done),
    .cf_ap_ready (cf_ap_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .cfg_clamped (cfg_clamped)
`ifdef CROP_WDOG_EN
    , .wdog_err  (wdog_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: frame phases from the rules --------
  typedef enum {P_IDLE, P_ARM, P_STREAM, P_DRAIN, P_DONE} phase_t;
  phase_t m_ph, m_nxt;
  int     m_beats, m_frames, m_sx, m_sy, m_cx, m_cy, m_drain;
  bit     m_clamped, m_done_seen, m_wderr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = P_IDLE; m_beats = 0; m_frames = 0; m_sx = 0; m_sy = 0;
      m_cx = 0; m_cy = 0; m_drain = 0; m_clamped = 0; m_done_seen = 0; m_wderr = 0;
    end else begin
      m_nxt = m_ph;
      case (m_ph)
        P_IDLE, P_DONE: m_nxt = (enable && cf_ap_ready) ? P_ARM : P_IDLE;
        P_ARM: begin
          m_done_seen = 0; m_beats = 0; m_drain = 0; m_nxt = P_STREAM;
        end
        P_STREAM: begin
          if (cf_ap_done) m_done_seen = 1;
          if (up_tvalid && cf_tready) begin
            m_beats++;
            if (m_beats == NPIX) begin m_beats = 0; m_nxt = P_DRAIN; end
          end
        end
        P_DRAIN: begin
          if (m_done_seen || cf_ap_done) m_nxt = P_DONE;
`ifdef CROP_WDOG_EN
          else begin
            m_drain++;
            if (m_drain == WD) begin m_nxt = P_DONE; m_wderr = 1; end
          end
`endif
        end
        default: m_nxt = P_IDLE;
      endcase
      if (cfg_valid) begin
        m_sx = (int'(cfg_x0) > C - OC) ? C - OC : int'(cfg_x0);
        m_sy = (int'(cfg_y0) > R - OR) ? R - OR : int'(cfg_y0);
        if (int'(cfg_x0) > C - OC || int'(cfg_y0) > R - OR) m_clamped = 1;
      end
      if (m_nxt == P_ARM) begin m_cx = m_sx; m_cy = m_sy; end
      if (m_nxt == P_DONE) m_frames = (m_frames + 1) % 65536;
      m_ph = m_nxt;
    end
  end

  // ---------------- upstream / downstream handshake drivers ----------------
  int mode = 0;   // 0: both low, 1: both high, 2: random stalls
  always @(posedge clk) begin
    #1;
    case (mode)
      1:       begin up_tvalid = 1'b1; cf_tready = 1'b1; end
      2:       begin up_tvalid = ($urandom_range(0, 3) != 0); cf_tready = $urandom_range(0, 1) == 1; end
      default: begin up_tvalid = 1'b0; cf_tready = 1'b0; end
    endcase
  end

  // ---------------- compare process + crop ap_done responder ---------------
  int obs_beats = 0, obs_total = 0, starts = 0, pending = 0;
  int cyc = 0, last_cyc = 0, done_cyc = 0, done_delay = 1;
  bit early_done = 0, no_done = 0;

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      check("up_tready",   up_tready,   cf_tready && m_ph == P_STREAM);
      check("cf_tvalid",   cf_tvalid,   up_tvalid && m_ph == P_STREAM);
      check("busy",        busy,        m_ph != P_IDLE);
      check("ap_start",    cf_ap_start, m_ph == P_ARM);
      check("frame_done",  frame_done,  m_ph == P_DONE);
      check("cnt_col",     cnt_col,     m_beats % C);
      check("cnt_row",     cnt_row,     m_beats / C);
      check("crop_x0",     crop_x0,     m_cx);
      check("crop_y0",     crop_y0,     m_cy);
      check("frame_count", frame_count, m_frames);
      check("cfg_clamped", cfg_clamped, m_clamped);
`ifdef CROP_WDOG_EN
      check("wdog_err",    wdog_err,    m_wderr);
`endif
      if (cf_ap_start) starts++;
      if (frame_done) done_cyc = cyc;
      cf_ap_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0 && !no_done) cf_ap_done = 1'b1;
      end
      if (up_tvalid && up_tready) begin
        obs_beats++;
        obs_total++;
        if ((early_done && obs_beats == 60) || (!early_done && obs_beats == NPIX))
          pending = done_delay;
        if (obs_beats == NPIX) begin obs_beats = 0; last_cyc = cyc; end
      end
    end else begin
      obs_beats  = 0;
      pending    = 0;
      cf_ap_done = 1'b0;
    end
  end

  // ---------------- directed sequence helpers ------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [2:0] x, input logic [2:0] y);
    step();
    cfg_valid = 1'b1; cfg_x0 = x; cfg_y0 = y;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin step(); n++; end
    check("busy_reached", busy, 1);
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    step();
    while (!frame_done && n < budget) begin step(); n++; end
    check("frame_done_reached", frame_done, 1);
  endtask

  task automatic wait_beats(input int k, input int budget);
    int n = 0;
    while (obs_beats != k && n < budget) begin step(); n++; end
    check("beat_reached", obs_beats, k);
  endtask

  task automatic run_one_frame();
    enable = 1'b1;
    wait_busy(20);
    enable = 1'b0;
    wait_frame(3000);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_x0 = '0; cfg_y0 = '0;
    cf_ap_ready = 1'b0;
    repeat (3) step();
    check("rst_busy",        busy,        0);
    check("rst_frame_count", frame_count, 0);
    check("rst_crop_x0",     crop_x0,     0);
    check("rst_cfg_clamped", cfg_clamped, 0);
    reset = 1'b0; mode = 1; cf_ap_ready = 1'b1;

    // Basic frame at (2,3).
    apply_cfg(3'd2, 3'd3);
    check("noclamp_2_3", cfg_clamped, 0);
    run_one_frame();
    check("basic_count",   frame_count, 1);
    check("basic_x0",      crop_x0,     2);
    check("basic_y0",      crop_y0,     3);
    check("basic_starts",  starts,      1);
    check("basic_beats",   obs_total,   64);
    check("basic_latency", done_cyc - last_cyc, 2);

    // Clamp (7,6) -> (4,4).
    apply_cfg(3'd7, 3'd6);
    check("clamp_sticky", cfg_clamped, 1);
    run_one_frame();
    check("clamp_x0", crop_x0, 4);
    check("clamp_y0", crop_y0, 4);

    // Mid-frame cfg with back-to-back frames.
    apply_cfg(3'd2, 3'd3);
    enable = 1'b1;
    wait_beats(20, 200);
    cfg_valid = 1'b1; cfg_x0 = 3'd1; cfg_y0 = 3'd1;
    step();
    cfg_valid = 1'b0;
    check("mid_keep_x0", crop_x0, 2);
    check("mid_keep_y0", crop_y0, 3);
    wait_frame(500);
    step();
    check("b2b_busy",  busy,        1);
    check("b2b_start", cf_ap_start, 1);
    check("next_x0",   crop_x0,     1);
    check("next_y0",   crop_y0,     1);

    // Backpressure and early ap_done over two frames.
    mode = 2; early_done = 1'b1;
    wait_frame(3000);
    wait_frame(3000);
    check("bp_count", frame_count, 5);
    check("bp_beats", obs_total,   320);

    // Reset at beat 30 of a running frame.
    mode = 1; early_done = 1'b0;
    wait_beats(30, 300);
    reset = 1'b1;
    #1;
    check("arst_busy",  busy,        0);
    check("arst_col",   cnt_col,     0);
    check("arst_row",   cnt_row,     0);
    check("arst_count", frame_count, 0);
    enable = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    run_one_frame();
    check("recover_count", frame_count, 1);
    check("recover_x0",    crop_x0,     0);

`ifdef CROP_WDOG_EN
    no_done = 1'b1;
    run_one_frame();
    check("wdog_err_set",  wdog_err, 1);
    check("wdog_latency",  done_cyc - last_cyc, WD + 1);
    no_done = 1'b0;
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
